// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with one registered response slot per port and the {Z,V,N} flag register.
module alu_arbiter #(
  parameter int         WIDTH    = 16,
  parameter logic [2:0] FLAG_RST = 3'b000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [3:0]       req_op0,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [3:0]       req_sh0,
  input  logic [3:0]       req_op1,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [3:0]       req_sh1,
  output logic [3:0]       alu_inst,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [3:0]       alu_shamt,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_z,
  input  logic             alu_v,
  input  logic             alu_n,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_data0,
  output logic [WIDTH-1:0] rsp_data1,
  output logic [2:0]       flags
);

  logic       last_grant;
  logic [1:0] elig;
  logic [1:0] grant;

  // a port may go when its slot is empty or being drained this cycle
  assign elig      = req_valid & (~rsp_valid | rsp_ready);
  assign req_ready = grant;

  // round-robin pick; a tie goes to the port that did not win last
  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (elig == 2'b11): grant = last_grant ? 2'b01 : 2'b10;
      (elig == 2'b01): grant = 2'b01;
      (elig == 2'b10): grant = 2'b10;
      default:         grant = 2'b00;
    endcase
  end

  // steer the granted request onto the ALU, zeros when idle
  always_comb begin
    alu_inst  = '0;
    alu_in1   = '0;
    alu_in2   = '0;
    alu_shamt = '0;
    unique case (1'b1)
      grant[0]: begin
        alu_inst  = req_op0;
        alu_in1   = req_a0;
        alu_in2   = req_b0;
        alu_shamt = req_sh0;
      end
      grant[1]: begin
        alu_inst  = req_op1;
        alu_in1   = req_a1;
        alu_in2   = req_b1;
        alu_shamt = req_sh1;
      end
      default: ;
    endcase
  end

  // remember the winner so the next tie flips
  always_ff @(posedge clk) begin
    if (!rst_n)
      last_grant <= 1'b1;
    else if (grant != 2'b00)
      last_grant <= grant[1];
  end

  // port 0 slot: a grant loads, a pop without a grant empties
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid[0] <= 1'b0;
      rsp_data0    <= '0;
    end else if (grant[0]) begin
      rsp_valid[0] <= 1'b1;
      rsp_data0    <= alu_out;
    end else if (rsp_ready[0]) begin
      rsp_valid[0] <= 1'b0;
    end
  end

  // port 1 slot: same rules as port 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid[1] <= 1'b0;
      rsp_data1    <= '0;
    end else if (grant[1]) begin
      rsp_valid[1] <= 1'b1;
      rsp_data1    <= alu_out;
    end else if (rsp_ready[1]) begin
      rsp_valid[1] <= 1'b0;
    end
  end

  // only execute-stage ops touch flags; ADD/SUB write all, others Z only
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags <= FLAG_RST;
    end else if (grant[0] && !req_op0[3]) begin
      flags[2] <= alu_z;
      if (req_op0[3:1] == 3'b000) begin
        flags[1] <= alu_v;
        flags[0] <= alu_n;
      end
    end
  end

  // sanity checks on grant shape, slot fill and flag stability
  always @(posedge clk) begin
    if (rst_n) begin
      assert ($onehot0(grant));
    end
    if (rst_n && $past(rst_n)) begin
      assert (!(rsp_valid[0] && !$past(rsp_valid[0]) && !$past(grant[0])));
      assert (!(rsp_valid[1] && !$past(rsp_valid[1]) && !$past(grant[1])));
      if (!$past(grant[0]))
        assert (flags == $past(flags));
    end
  end

endmodule
